// File: rtl/ram_pkg.sv
// Shared types for the RAM copy/fill sequencer: FSM states and operation codes.
package ram_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      FILL  = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/ram_copy_engine_if.sv
// Control request/status plus one synchronous RAM port; master is the engine side.
interface ram_copy_engine_if #(
   parameter int N = 6,
   parameter int M = 32
);
   logic         start;
   logic         op;
   logic [N-1:0] src;
   logic [N-1:0] dst;
   logic [N:0]   len;
   logic [M-1:0] fill_val;
   logic         busy;
   logic         done;
   logic [N-1:0] addr;
   logic         we;
   logic [M-1:0] wd;
   logic [M-1:0] rd;

   modport master (
      input  start, op, src, dst, len, fill_val, rd,
      output busy, done, addr, we, wd
   );

   modport slave (
      output start, op, src, dst, len, fill_val, rd,
      input  busy, done, addr, we, wd
   );
endinterface

// File: rtl/ram_copy_engine.sv
// Fills a RAM block with a constant or copies a block word-by-word (read, then write) through one port.
// COPY takes 2 cycles/word, FILL 1 cycle/word, plus one DONE cycle; start is ignored while busy.
module ram_copy_engine
   import ram_pkg::*;
#(
   parameter int N = 6,
   parameter int M = 32
) (
   input  logic              clk,
   input  logic              reset,
   ram_copy_engine_if.master bus
);

   localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};
   localparam logic [N:0] ONE   = {{N{1'b0}}, 1'b1};

   state_e       state_q, state_d;
   logic [N:0]   i_q, i_d;
   logic         op_q;
   logic [N-1:0] src_q;
   logic [N-1:0] dst_q;
   logic [N:0]   len_q;
   logic [M-1:0] fill_q;
   logic         capture;
   logic [N:0]   len_clamped;
   logic [N:0]   i_inc;

   assign len_clamped = (bus.len > DEPTH) ? DEPTH : bus.len;
   assign i_inc       = i_q + ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         op_q    <= OP_COPY;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         if (capture) begin
            op_q   <= bus.op;
            src_q  <= bus.src;
            dst_q  <= bus.dst;
            len_q  <= len_clamped;
            fill_q <= bus.fill_val;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      capture  = 1'b0;
      bus.addr = '0;
      bus.we   = 1'b0;
      bus.wd   = '0;
      bus.done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               capture = 1'b1;
               i_d     = '0;
               if (len_clamped == '0)      state_d = DONE;
               else if (bus.op == OP_FILL) state_d = FILL;
               else                        state_d = READ;
            end
         end
         READ: begin
            bus.addr = src_q + i_q[N-1:0];
            state_d  = WRITE;
         end
         WRITE: begin
            // rd holds the word addressed in the preceding READ cycle
            bus.addr = dst_q + i_q[N-1:0];
            bus.we   = 1'b1;
            bus.wd   = bus.rd;
            i_d      = i_inc;
            state_d  = (i_inc == len_q) ? DONE : READ;
         end
         FILL: begin
            bus.addr = dst_q + i_q[N-1:0];
            bus.we   = 1'b1;
            bus.wd   = fill_q;
            i_d      = i_inc;
            state_d  = (i_inc == len_q) ? DONE : FILL;
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_ram_copy_engine.sv
// Drives ram_copy_engine against a registered-read RAM and checks cycle timing and RAM contents.
module tb_ram_copy_engine;
   import ram_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];

   ram_copy_engine_if #(.N(6), .M(32)) bus ();

   ram_copy_engine #(.N(6), .M(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Port 1 of the RAM: registered read, write on the same edge.
   always @(posedge clk) begin
      if (bus.we) mem[bus.addr] <= bus.wd;
      bus.rd <= mem[bus.addr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int a = 0; a < 64; a++) if (mem[a] !== ref_mem[a]) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic set_word(input int a, input logic [31:0] v);
      mem[a & 63]     = v;
      ref_mem[a & 63] = v;
   endtask

   task automatic scramble();
      bus.op       = 1'($urandom);
      bus.src      = 6'($urandom);
      bus.dst      = 6'($urandom);
      bus.len      = 7'($urandom);
      bus.fill_val = $urandom;
   endtask

   // Call positioned just after a negedge while idle; returns the same way, one idle cycle later.
   task automatic run_op(input string tag, input logic o, input int s, input int d, input int l,
                         input logic [31:0] fv, input bit poke);
      int eff, exp_done, cyc, j;
      eff      = (l > 64) ? 64 : l;
      exp_done = (eff == 0) ? 1 : ((o == OP_COPY) ? 1 + 2 * eff : 1 + eff);
      bus.start    = 1'b1;
      bus.op       = o;
      bus.src      = 6'(s);
      bus.dst      = 6'(d);
      bus.len      = 7'(l);
      bus.fill_val = fv;
      @(posedge clk);
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         chk({tag, "_busy"}, bus.busy, 1);
         if (cyc == exp_done) begin
            chk({tag, "_done"}, bus.done, 1);
            chk({tag, "_we_done"}, bus.we, 0);
         end else if (cyc < exp_done) begin
            chk({tag, "_nodone"}, bus.done, 0);
            if (o == OP_FILL) begin
               j = cyc - 1;
               chk({tag, "_we"}, bus.we, 1);
               chk({tag, "_addr"}, bus.addr, (d + j) & 63);
               chk({tag, "_wd"}, bus.wd, fv);
               ref_mem[(d + j) & 63] = fv;
            end else if (cyc % 2 == 1) begin
               j = (cyc - 1) / 2;
               chk({tag, "_we"}, bus.we, 0);
               chk({tag, "_raddr"}, bus.addr, (s + j) & 63);
            end else begin
               j = (cyc - 2) / 2;
               chk({tag, "_we"}, bus.we, 1);
               chk({tag, "_waddr"}, bus.addr, (d + j) & 63);
               chk({tag, "_wd"}, bus.wd, ref_mem[(s + j) & 63]);
               ref_mem[(d + j) & 63] = ref_mem[(s + j) & 63];
            end
         end
         if (cyc == 1) begin
            bus.start = 1'b0;
            scramble();
         end
         if (poke && cyc == 2) begin
            bus.start = 1'b1;
            bus.dst   = 6'(d ^ 32);
            bus.op    = OP_FILL;
            bus.len   = 7'd5;
         end
         if (poke && cyc == 3) bus.start = 1'b0;
         if (bus.done || cyc >= exp_done) break;
      end
      chk({tag, "_done_cycle"}, cyc, exp_done);
      @(negedge clk);
      chk({tag, "_idle_busy"}, bus.busy, 0);
      chk({tag, "_idle_done"}, bus.done, 0);
      chk({tag, "_idle_we"}, bus.we, 0);
      check_mem({tag, "_mem"});
   endtask

   initial begin
      int cyc;
      reset     = 1'b1;
      bus.start = 1'b0;
      scramble();
      for (int a = 0; a < 64; a++) set_word(a, $urandom);
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_wd", bus.wd, 0);
      reset = 1'b0;
      @(negedge clk);

      run_op("fill8", OP_FILL, 8, 8, 4, 32'hDEAD_BEEF, 0);
      chk("fill8_w11", mem[11], 32'hDEAD_BEEF);

      set_word(0, 1); set_word(1, 2); set_word(2, 3);
      run_op("copy3", OP_COPY, 0, 32, 3, 0, 0);
      chk("copy3_w34", mem[34], 3);

      set_word(62, 32'hA); set_word(63, 32'hB); set_word(0, 32'hC); set_word(1, 32'hD);
      run_op("wrap", OP_COPY, 62, 0, 4, 0, 0);
      chk("wrap_w2", mem[2], 32'hA);
      chk("wrap_w3", mem[3], 32'hB);

      run_op("len0", OP_COPY, 5, 9, 0, 0, 0);
      run_op("len100", OP_FILL, 0, 17, 100, 32'h1234_5678, 0);
      chk("len100_w16", mem[16], 32'h1234_5678);

      run_op("poke", OP_FILL, 0, 20, 10, 32'hCAFE_0001, 1);

      // Reset during the third WRITE of an 8-word copy.
      bus.start = 1'b1; bus.op = OP_COPY; bus.src = 6'd10; bus.dst = 6'd40;
      bus.len = 7'd8; bus.fill_val = 0;
      @(posedge clk);
      for (cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin bus.start = 1'b0; scramble(); end
      end
      chk("rst_mid_we", bus.we, 1);
      reset = 1'b1;
      for (int j = 0; j < 3; j++) ref_mem[(40 + j) & 63] = ref_mem[(10 + j) & 63];
      @(negedge clk);
      chk("rst_mid_we0", bus.we, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_done", bus.done, 0);
      chk("rst_mid_addr", bus.addr, 0);
      reset = 1'b0;
      cyc = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done || bus.we || bus.busy) cyc++;
      end
      chk("rst_mid_quiet", cyc, 0);
      check_mem("rst_mid_mem");

      for (int t = 0; t < 25; t++) begin
         run_op("rand", 1'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 72), $urandom, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
